// File: rtl/fadd_issue.sv
// Issue/collect front end for a fixed-latency pipelined FP adder: operand issue
// register, tag/valid shift pipe, in-order result FIFO and credit-based flow control.
module fadd_issue #(
    parameter int LAT   = 2,
    parameter int DEPTH = 8,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [31:0]      in_s,
    input  logic [31:0]      in_t,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      fa_s,
    output logic [31:0]      fa_t,
    input  logic [31:0]      fa_d,
    input  logic             fa_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_d,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_overflow,
    output logic             busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 33 + TAG_W;

    function automatic logic [31:0] negate(input logic [31:0] v);
        return {~v[31], v[30:0]};
    endfunction

    function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic fire, pop, wr_en;

    assign fire  = in_valid && in_ready;
    assign pop   = out_valid && out_ready;

    // Stage p0: issue register drives the adder operands
    logic [31:0] fa_s_q, fa_t_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fa_s_q <= '0;
            fa_t_q <= '0;
        end else if (fire) begin
            fa_s_q <= in_s;
            fa_t_q <= in_op ? negate(in_t) : in_t;
        end
    end

    assign fa_s = fa_s_q;
    assign fa_t = fa_t_q;

    // Stages p1..pLAT: tag/valid pipe tracks the adder latency
    logic [LAT:0]       vld_p;
    logic [TAG_W-1:0]   tag_p [LAT+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p <= {vld_p[LAT-1:0], fire};
        end
    end

    always_ff @(posedge clk) begin
        tag_p[0] <= in_tag;
        for (int k = 1; k <= LAT; k++) begin
            tag_p[k] <= tag_p[k-1];
        end
    end

    assign wr_en = vld_p[LAT];

    // Result FIFO capture, aligned with the adder output
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d, occ_q, occ_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_q] <= {fa_overflow, tag_p[LAT], fa_d};
        end
    end

    always_comb begin
        wr_d  = wr_en ? inc_ptr(wr_q) : wr_q;
        rd_d  = pop ? inc_ptr(rd_q) : rd_q;
        cnt_d = cnt_q;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // Credit covers ops still inside the adder as well as buffered results
        occ_d = occ_q;
        case ({fire, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            occ_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            occ_q <= occ_d;
        end
    end

    logic [EW-1:0] head;

    assign head         = mem[rd_q];
    assign out_valid    = (cnt_q != '0);
    assign out_d        = out_valid ? head[31:0] : '0;
    assign out_tag      = out_valid ? head[TAG_W+31:32] : '0;
    assign out_overflow = out_valid ? head[EW-1] : 1'b0;
    assign in_ready     = (occ_q < CW'(DEPTH));
    assign busy         = (occ_q != '0);
endmodule

// File: tb/tb_fadd_issue.sv
// Directed bench for fadd_issue with a behavioural two-stage float adder and
// a result scoreboard checked whenever the DUT pops a result.
`define CHK(n, o, e) chk(n, 64'(o), 64'(e))

module tb_fadd_issue;
  localparam int LAT = 2, DEPTH = 8, TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, in_op, out_valid, out_ready;
  logic             fa_overflow, out_overflow, busy;
  logic [31:0]      in_s, in_t, fa_s, fa_t, fa_d, out_d;
  logic [TAG_W-1:0] in_tag, out_tag;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             ovf;
    logic [31:0]      d;
  } res_t;

  res_t sb[$];
  int   checks = 0, errors = 0, nfire = 0;

  fadd_issue #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_s(in_s), .in_t(in_t), .in_tag(in_tag), .fa_s(fa_s), .fa_t(fa_t),
    .fa_d(fa_d), .fa_overflow(fa_overflow), .out_valid(out_valid),
    .out_ready(out_ready), .out_d(out_d), .out_tag(out_tag),
    .out_overflow(out_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Single-precision <-> double conversion (normals, zero, inf/NaN; truncating)
  function automatic real s2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'h00) d = {b[31], 63'd0};
    else if (b[30:23] == 8'hFF) d = {b[31], 11'h7FF, b[22:0], 29'd0};
    else d = {b[31], {3'b000, b[30:23]} + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [32:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52];
    if (e == 11'h7FF) return {1'b0, d[63], 8'hFF, d[51:29]};
    if (e > 11'd1150) return {1'b1, d[63], 8'hFF, 23'd0};
    if (e < 11'd897)  return {1'b0, d[63], 31'd0};
    return {1'b0, d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  function automatic logic [32:0] fadd_model(input logic [31:0] s, input logic [31:0] t);
    return r2s(s2r(s) + s2r(t));
  endfunction

  logic [32:0] add_s1 = '0, add_s2 = '0;
  always @(posedge clk) begin
    add_s1 <= fadd_model(fa_s, fa_t);
    add_s2 <= add_s1;
  end
  assign fa_d        = add_s2[31:0];
  assign fa_overflow = add_s2[32];

  always @(posedge clk) begin
    if (!rst && dut.wr_en && !dut.pop) begin
      checks++;
      if (dut.cnt_q >= DEPTH) begin
        errors++;
        $error("FAIL fifo_full_write: write to full FIFO, cnt %0d", dut.cnt_q);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  // One clock: check credit state, score any pop, record any fire, advance
  task automatic tick();
    logic fire, pop;
    res_t e;
    if (!rst) begin
      `CHK("in_ready_credit", in_ready, sb.size() < DEPTH);
      `CHK("busy_credit", busy, sb.size() != 0);
    end
    fire = in_valid && in_ready && !rst;
    pop  = out_valid && out_ready && !rst;
    if (pop) begin
      if (sb.size() == 0) begin
        `CHK("unexpected_pop", out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        `CHK("res_d", out_d, e.d);
        `CHK("res_tag", out_tag, e.tag);
        `CHK("res_ovf", out_overflow, e.ovf);
      end
    end
    if (fire) begin
      e.tag = in_tag;
      {e.ovf, e.d} = fadd_model(in_s, in_op ? {~in_t[31], in_t[30:0]} : in_t);
      sb.push_back(e);
      nfire++;
    end
    if (rst) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    `CHK(name, out_valid, 1'b1);
  endtask

  task automatic drive(input logic op, input logic [31:0] s, input logic [31:0] t,
                       input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_s     = s;
    in_t     = t;
    in_tag   = tag;
  endtask

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_s = '0; in_t = '0; in_tag = '0;
    out_ready = 1'b1;
    #1;
    tick();
    tick();
    rst = 1'b0;

    `CHK("rst_in_ready", in_ready, 1'b1);
    `CHK("rst_out_valid", out_valid, 1'b0);
    `CHK("rst_out_d", out_d, 32'h0);
    `CHK("rst_out_tag", out_tag, 6'd0);
    `CHK("rst_out_ovf", out_overflow, 1'b0);
    `CHK("rst_fa_s", fa_s, 32'h0);
    `CHK("rst_fa_t", fa_t, 32'h0);
    `CHK("rst_busy", busy, 1'b0);

    // Add 1.0 + 2.0, exact three-cycle latency
    drive(1'b0, 32'h3F800000, 32'h40000000, 6'd5);
    tick();
    in_valid = 1'b0;
    `CHK("add_fa_s", fa_s, 32'h3F800000);
    `CHK("add_lat0", out_valid, 1'b0);
    tick();
    `CHK("add_lat1", out_valid, 1'b0);
    tick();
    `CHK("add_lat2", out_valid, 1'b0);
    tick();
    `CHK("add_lat3", out_valid, 1'b1);
    `CHK("add_d", out_d, 32'h40400000);
    `CHK("add_tag", out_tag, 6'd5);
    `CHK("add_ovf", out_overflow, 1'b0);
    checks++;
    if (out_d !== 32'h40400000 || out_tag !== 6'd5) begin
      errors++;
      $error("FAIL add_result: d %0h tag %0d", out_d, out_tag);
    end
    tick();
    `CHK("add_drained", out_valid, 1'b0);

    // Sub 3.0 - 1.0
    drive(1'b1, 32'h40400000, 32'h3F800000, 6'd9);
    tick();
    in_valid = 1'b0;
    `CHK("sub_fa_t", fa_t, 32'hBF800000);
    checks++;
    if (fa_t !== 32'hBF800000) begin
      errors++;
      $error("FAIL sub_fa_t_direct: %0h", fa_t);
    end
    wait_valid("sub_timeout");
    `CHK("sub_d", out_d, 32'h40000000);
    `CHK("sub_tag", out_tag, 6'd9);
    checks++;
    if (out_d !== 32'h40000000) begin
      errors++;
      $error("FAIL sub_result: %0h", out_d);
    end
    tick();

    // Overflow: max + max
    drive(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 6'd33);
    tick();
    in_valid = 1'b0;
    wait_valid("ovf_timeout");
    `CHK("ovf_d", out_d, 32'h7F800000);
    `CHK("ovf_flag", out_overflow, 1'b1);
    checks++;
    if (out_d !== 32'h7F800000 || out_overflow !== 1'b1) begin
      errors++;
      $error("FAIL ovf_result: d %0h ovf %0b", out_d, out_overflow);
    end
    tick();

    // Streaming: 16 back-to-back ops
    for (int i = 0; i < 16; i++) begin
      drive(i[0], 32'h3F800000 + (i << 19), 32'h40000000 + (i << 18), 6'(i));
      `CHK("stream_ready", in_ready, 1'b1);
      if (i >= 4) `CHK("stream_valid", out_valid, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      `CHK("stream_tail_valid", out_valid, 1'b1);
      tick();
    end
    `CHK("stream_empty", out_valid, 1'b0);

    // Back-pressure: only DEPTH ops accepted while the output is stalled
    out_ready = 1'b0;
    base = nfire;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 32'h3F800000, 32'h3F800000 + (i << 20), 6'(16 + i));
      tick();
    end
    in_valid = 1'b0;
    `CHK("bp_fires", nfire - base, DEPTH);
    checks++;
    if (nfire - base != DEPTH) begin
      errors++;
      $error("FAIL bp_fires_direct: %0d", nfire - base);
    end
    `CHK("bp_in_ready_low", in_ready, 1'b0);
    tick();
    tick();
    `CHK("bp_held_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    `CHK("bp_ready_before_pop", in_ready, 1'b0);
    tick();
    `CHK("bp_ready_after_pop", in_ready, 1'b1);
    for (int i = 0; i < 12 && sb.size() != 0; i++) tick();
    `CHK("bp_drained", out_valid, 1'b0);

    // Reset mid-flight drops in-flight results
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h40000000, 32'h40000000, 6'(50 + i));
      tick();
    end
    in_valid = 1'b0;
    `CHK("mid_pre_rst_valid", out_valid, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    `CHK("mid_in_ready", in_ready, 1'b1);
    `CHK("mid_busy", busy, 1'b0);
    `CHK("mid_out_d", out_d, 32'h0);
    for (int i = 0; i < 5; i++) begin
      `CHK("mid_no_valid", out_valid, 1'b0);
      tick();
    end
    drive(1'b0, 32'h3F800000, 32'h3F800000, 6'd42);
    tick();
    in_valid = 1'b0;
    wait_valid("post_rst_timeout");
    `CHK("post_rst_d", out_d, 32'h40000000);
    `CHK("post_rst_tag", out_tag, 6'd42);
    checks++;
    if (out_d !== 32'h40000000 || out_tag !== 6'd42) begin
      errors++;
      $error("FAIL post_rst_result: d %0h tag %0d", out_d, out_tag);
    end
    tick();
    `CHK("post_rst_empty", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
